// File: rtl/reg_array_mp_pkg.sv
// rtl/reg_array_mp_pkg.sv - shared defaults and clear-FSM state encodings
package mips789_defs;

  localparam int DEF_DW  = 32;
  localparam int DEF_AW  = 5;
  localparam int DEF_NRD = 2;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_e;

endpackage

// File: rtl/reg_array_mp_clear_seq.sv
// rtl/reg_array_mp_clear_seq.sv - post-reset sweep that zeroes every bank entry
module rf_clear_seq
  import mips789_defs::*;
#(
  parameter int AW = DEF_AW
) (
  input  logic          clock,
  input  logic          rst,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  rf_state_e     state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  // Walk the counter through every address once, then park in RUN until reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == RF_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (&cnt_q) begin
        state_d = RF_RUN;
      end
    end
  end

  // State and counter registers; reset restarts the sweep from address 0.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= RF_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy     = (state_q == RF_CLEAR);
  assign clr_we   = busy & ~rst;
  assign clr_addr = cnt_q;

endmodule

// File: rtl/reg_array_mp.sv
// rtl/reg_array_mp.sv - multi-read-port register array with write forwarding and clear sweep
module reg_array_mp
  import mips789_defs::*;
#(
  parameter int DW       = DEF_DW,
  parameter int AW       = DEF_AW,
  parameter int NRD      = DEF_NRD,
  parameter int ZERO_REG = 1,
  parameter int WR_FWD   = 1
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              pause,
  input  logic              rd_clk_cls,
  input  logic              wren,
  input  logic [AW-1:0]     wraddress,
  input  logic [DW-1:0]     data,
  input  logic [NRD*AW-1:0] rdaddress,
  output logic [NRD*DW-1:0] q,
  output logic              busy
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] bank [DEPTH];

  logic [DW-1:0] r_data_q, r_data_d;
  logic [AW-1:0] r_wraddress_q, r_wraddress_d;
  logic          r_wren_q, r_wren_d;
  logic [AW-1:0] r_rdaddr_q [NRD];
  logic [AW-1:0] r_rdaddr_d [NRD];

  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic          host_we;
  logic          bank_we;
  logic [AW-1:0] bank_waddr;
  logic [DW-1:0] bank_wdata;

  rf_clear_seq #(.AW(AW)) u_clear_seq (
    .clock    (clock),
    .rst      (rst),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Capture stage: pause freezes everything, rd_clk_cls freezes only read addresses,
  // and host writes are squashed while the clear sweep owns the bank.
  always_comb begin
    r_data_d      = r_data_q;
    r_wraddress_d = r_wraddress_q;
    r_wren_d      = r_wren_q;
    if (!pause) begin
      r_data_d      = data;
      r_wraddress_d = wraddress;
      r_wren_d      = wren;
    end
    if (busy) begin
      r_wren_d = 1'b0;
    end
    for (int k = 0; k < NRD; k++) begin
      r_rdaddr_d[k] = r_rdaddr_q[k];
      if (!pause && !rd_clk_cls) begin
        r_rdaddr_d[k] = rdaddress[k*AW +: AW];
      end
    end
  end

  // Capture registers.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_data_q      <= '0;
      r_wraddress_q <= '0;
      r_wren_q      <= 1'b0;
      for (int k = 0; k < NRD; k++) begin
        r_rdaddr_q[k] <= '0;
      end
    end else begin
      r_data_q      <= r_data_d;
      r_wraddress_q <= r_wraddress_d;
      r_wren_q      <= r_wren_d;
      for (int k = 0; k < NRD; k++) begin
        r_rdaddr_q[k] <= r_rdaddr_d[k];
      end
    end
  end

  // Single bank write port: the clear sweep wins, writes to a hard-wired zero entry are dropped.
  always_comb begin
    host_we    = r_wren_q && !((ZERO_REG != 0) && (r_wraddress_q == '0));
    bank_we    = clr_we | (host_we & ~rst);
    bank_waddr = clr_we ? clr_addr : r_wraddress_q;
    bank_wdata = clr_we ? '0 : r_data_q;
  end

  // Bank storage; contents are defined by the clear sweep rather than by reset.
  always_ff @(posedge clock) begin
    if (bank_we) begin
      bank[bank_waddr] <= bank_wdata;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [DW-1:0] q_k;

    // Read mux: zero entry and clear sweep first, then pending write, then bank.
    always_comb begin
      q_k = bank[r_rdaddr_q[k]];
      if ((WR_FWD != 0) && r_wren_q && (r_wraddress_q == r_rdaddr_q[k])) begin
        q_k = r_data_q;
      end
      if (((ZERO_REG != 0) && (r_rdaddr_q[k] == '0)) || busy) begin
        q_k = '0;
      end
    end

    assign q[k*DW +: DW] = q_k;
  end

endmodule

// File: tb/tb_reg_array_mp.sv
// tb/tb_reg_array_mp.sv - scoreboard bench for reg_array_mp (default build and no-zero/no-forward build)
module tb_reg_array_mp;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        pause = 1'b0;
  logic        rd_clk_cls = 1'b0;
  logic        wren = 1'b0;
  logic [4:0]  wraddress = '0;
  logic [31:0] data = '0;
  logic [9:0]  rdaddress = '0;
  logic [63:0] q_main, q_alt;
  logic        busy_main, busy_alt;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  localparam int S_M0 = 0, S_M1 = 1, S_A0 = 2, S_A1 = 3, S_MB = 4, S_AB = 5;

  typedef struct {
    int          due;
    int          sel;
    logic [31:0] exp;
    string       name;
  } sb_t;

  sb_t sb[$];

  reg_array_mp u_main (
    .clock(clock), .rst(rst), .pause(pause), .rd_clk_cls(rd_clk_cls), .wren(wren),
    .wraddress(wraddress), .data(data), .rdaddress(rdaddress), .q(q_main), .busy(busy_main)
  );

  reg_array_mp #(.ZERO_REG(0), .WR_FWD(0)) u_alt (
    .clock(clock), .rst(rst), .pause(pause), .rd_clk_cls(rd_clk_cls), .wren(wren),
    .wraddress(wraddress), .data(data), .rdaddress(rdaddress), .q(q_alt), .busy(busy_alt)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] actual(int sel);
    case (sel)
      S_M0:    return q_main[31:0];
      S_M1:    return q_main[63:32];
      S_A0:    return q_alt[31:0];
      S_A1:    return q_alt[63:32];
      S_MB:    return {31'd0, busy_main};
      default: return {31'd0, busy_alt};
    endcase
  endfunction

  // Monitor: compare every expectation due after this cycle's edge.
  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      sb_t e;
      logic [31:0] act;
      e = sb.pop_front();
      act = actual(e.sel);
      checks++;
      if (e.due != cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d not checked in time (now %0d)", e.name, e.due, cyc);
      end else if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", e.name, act, e.exp, cyc);
      end
    end
  end

  task automatic push(input int sel, input logic [31:0] exp, input string name);
    sb.push_back('{cyc + 1, sel, exp, name});
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    rdaddress = {a1, a0};
  endtask

  task automatic set_wr(input logic en, input logic [4:0] a, input logic [31:0] d);
    wren = en;
    wraddress = a;
    data = d;
  endtask

  initial begin
    // Reset held three cycles.
    set_rd(5'd3, 5'd31);
    for (int i = 0; i < 3; i++) begin
      push(S_MB, 32'd1, "rst_busy");
      push(S_M0, 32'd0, "rst_q0");
      push(S_M1, 32'd0, "rst_q1");
      step();
    end
    rst = 1'b0;

    // Busy for exactly 32 edges after release, q stays zero meanwhile.
    for (int i = 1; i <= 32; i++) begin
      push(S_MB, (i < 32) ? 32'd1 : 32'd0, "clear_busy");
      if (i < 32) push(S_M1, 32'd0, "clear_q1");
      step();
    end
    push(S_AB, 32'd0, "alt_busy_done");
    step();

    // Every address reads zero after the sweep.
    for (int a = 0; a < 32; a++) begin
      set_rd(a[4:0], 5'(31 - a));
      push(S_M0, 32'd0, "post_clear_q0");
      push(S_M1, 32'd0, "post_clear_q1");
      push(S_A0, 32'd0, "post_clear_alt_q0");
      step();
    end

    // Write R5 and read it in the same capture cycle: forwarded vs. old bank value.
    set_wr(1'b1, 5'd5, 32'hDEADBEEF);
    set_rd(5'd5, 5'd5);
    push(S_M0, 32'hDEADBEEF, "fwd_q0");
    push(S_M1, 32'hDEADBEEF, "fwd_q1");
    push(S_A0, 32'h0, "nofwd_old_q0");
    step();
    set_wr(1'b0, 5'd0, 32'h0);
    push(S_M0, 32'hDEADBEEF, "r5_q0");
    push(S_M1, 32'hDEADBEEF, "r5_q1");
    push(S_A0, 32'hDEADBEEF, "nofwd_bank_q0");
    push(S_A1, 32'hDEADBEEF, "nofwd_bank_q1");
    step();

    // Zero register: the write is dropped unless ZERO_REG=0.
    set_wr(1'b1, 5'd0, 32'hFFFFFFFF);
    set_rd(5'd0, 5'd0);
    push(S_M0, 32'h0, "r0_fwd_q0");
    push(S_M1, 32'h0, "r0_fwd_q1");
    step();
    set_wr(1'b0, 5'd0, 32'h0);
    push(S_M0, 32'h0, "r0_q0");
    push(S_M1, 32'h0, "r0_q1");
    push(S_A0, 32'hFFFFFFFF, "r0_alt_q0");
    push(S_A1, 32'hFFFFFFFF, "r0_alt_q1");
    step();

    // Stall: capture R7, then pause while inputs change.
    set_rd(5'd7, 5'd7);
    push(S_M0, 32'h0, "stall_pre_q0");
    step();
    pause = 1'b1;
    set_rd(5'd5, 5'd5);
    set_wr(1'b1, 5'd7, 32'h1234);
    for (int i = 0; i < 3; i++) begin
      push(S_M0, 32'h0, "stall_q0");
      push(S_M1, 32'h0, "stall_q1");
      push(S_A0, 32'h0, "stall_alt_q0");
      step();
    end
    pause = 1'b0;
    set_rd(5'd7, 5'd7);
    push(S_M0, 32'h1234, "unstall_fwd_q0");
    push(S_A0, 32'h0, "unstall_alt_old");
    step();
    set_wr(1'b0, 5'd0, 32'h0);
    push(S_M0, 32'h1234, "unstall_q0");
    push(S_A0, 32'h1234, "unstall_alt_q0");
    step();

    // rd_clk_cls holds the read address at R3 while writing R3.
    set_rd(5'd3, 5'd3);
    step();
    rd_clk_cls = 1'b1;
    set_rd(5'd9, 5'd9);
    set_wr(1'b1, 5'd3, 32'h55);
    push(S_M0, 32'h55, "cls_fwd_q0");
    push(S_M1, 32'h55, "cls_fwd_q1");
    push(S_A0, 32'h0, "cls_alt_old");
    step();
    set_wr(1'b0, 5'd0, 32'h0);
    push(S_M0, 32'h55, "cls_hold_q0");
    push(S_A0, 32'h55, "cls_alt_q0");
    step();
    rd_clk_cls = 1'b0;

    // Reset mid-clear, then a host write issued while still busy is lost.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step();
    rst = 1'b1;
    push(S_MB, 32'd1, "midclr_rst_busy");
    step();
    rst = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      if (i == 32) set_wr(1'b1, 5'd20, 32'hAA);
      push(S_MB, (i < 32) ? 32'd1 : 32'd0, "midclr_busy");
      push(S_AB, (i < 32) ? 32'd1 : 32'd0, "midclr_alt_busy");
      step();
    end
    set_wr(1'b0, 5'd0, 32'h0);
    set_rd(5'd20, 5'd20);
    push(S_M0, 32'h0, "lost_wr_q0");
    push(S_A0, 32'h0, "lost_wr_alt_q0");
    step();
    push(S_M1, 32'h0, "lost_wr_bank_q1");
    push(S_A1, 32'h0, "lost_wr_alt_q1");
    push(S_M0, 32'h0, "r5_cleared");
    set_rd(5'd5, 5'd20);
    step();

    @(negedge clock);
    #1;
    if (sb.size() != 0) begin
      errors += sb.size();
      checks += sb.size();
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
